// File: rtl/seq_div_16x8.sv
// ---------------------------------------------------------------------------
// seq_div_16x8
//   Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned
//   divisor -> 16-bit quotient, 8-bit remainder. One quotient bit per cycle.
//
//   Build option: define DIV_APPROX_EN to skip the APPROX_LSB low-order
//   iterations (shorter latency, low quotient bits forced to 0, R forced 0).
//
// Parameters
//   APPROX_LSB   low quotient bits not computed in the approximate build
//                (legal 0..15); ignored in the exact build.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        request, sampled only while idle
//   A [15:0]     dividend, captured when start is accepted
//   B [7:0]      divisor, captured when start is accepted
//   busy         high while an operation is in progress (not idle)
//   done         one-cycle pulse, Q/R/div_by_zero valid
//   Q [15:0]     quotient (16'hFFFF on divide by zero)
//   R [7:0]      remainder (A[7:0] on divide by zero)
//   div_by_zero  captured divisor was zero; valid with done
// ---------------------------------------------------------------------------
module seq_div_16x8 #(
    parameter int unsigned APPROX_LSB = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [7:0]  B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Q,
    output logic [7:0]  R,
    output logic        div_by_zero
);

`ifdef DIV_APPROX_EN
    localparam bit APPROX_ON = 1'b1;
`else
    localparam bit APPROX_ON = 1'b0;
`endif

    localparam int unsigned SKIP      = APPROX_ON ? APPROX_LSB : 0;
    localparam int unsigned NITER     = 16 - SKIP;
    localparam logic [4:0]  CNT_LOAD  = 5'(NITER - 1);
    // Counter value one step past zero: marks the bookkeeping cycle between
    // the last iteration (or a zero-divisor capture) and DONE.
    localparam logic [4:0]  CNT_DRAIN = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [7:0]  p_q,     p_d;
    logic [15:0] s_q,     s_d;
    logic [7:0]  b_q,     b_d;
    logic [15:0] quo_q,   quo_d;
    logic [7:0]  rem_q,   rem_d;
    logic        dbz_q,   dbz_d;

    logic [8:0]  t;
    logic [8:0]  b_ext;
    logic        q_bit;
    logic        iterating;
    logic        finishing;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            s_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            s_q     <= s_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q[4]) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring iteration and result capture
    // ------------------------------------------------------------------
    always_comb begin
        t     = {p_q, s_q[15]};
        b_ext = {1'b0, b_q};
        q_bit = (t >= b_ext);

        // cnt_q counts N-1 down to 0 with one iteration per value; the
        // wrap to all-ones (bit 4 set) is the final non-iterating RUN cycle.
        iterating = (state_q == S_RUN) && !cnt_q[4];
        finishing = (state_q == S_RUN) &&  cnt_q[4];

        cnt_d = cnt_q;
        p_d   = p_q;
        s_d   = s_q;
        b_d   = b_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dbz_d = dbz_q;

        if (state_q == S_IDLE && start) begin
            // s keeps A MSB-aligned in both builds; the approximate build
            // simply stops early, so only A[15:SKIP] ever reach the compare.
            s_d   = A;
            b_d   = B;
            p_d   = '0;
            cnt_d = (B == 8'd0) ? CNT_DRAIN : CNT_LOAD;
        end

        if (iterating) begin
            // t - B < B whenever the subtract is taken, so 8 bits suffice.
            p_d   = q_bit ? 8'(t - b_ext) : t[7:0];
            s_d   = {s_q[14:0], q_bit};
            cnt_d = cnt_q - 5'd1;
        end

        if (finishing) begin
            cnt_d = '0;
            if (b_q == 8'd0) begin
                // No iterations ran, so s still holds the captured A.
                quo_d = 16'hFFFF;
                rem_d = s_q[7:0];
                dbz_d = 1'b1;
            end else begin
                // After N shifts the quotient sits in s[N-1:0]; shifting by
                // SKIP drops the leftover dividend bits and zero-fills.
                quo_d = s_q << SKIP;
                rem_d = APPROX_ON ? 8'd0 : p_q;
                dbz_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        Q           = quo_q;
        R           = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_seq_div_16x8.sv
module tb_seq_div_16x8;

    localparam int unsigned L = 4;
`ifdef DIV_APPROX_EN
    localparam int unsigned N   = 16 - L;
    localparam bit          APX = 1'b1;
`else
    localparam int unsigned N   = 16;
    localparam bit          APX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [7:0]  B;
    logic        busy;
    logic        done;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        div_by_zero;

    always #5 clk = ~clk;

    seq_div_16x8 #(.APPROX_LSB(L)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .div_by_zero(div_by_zero)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    // Behavioural reference: plain arithmetic on the operands.
    function automatic logic [15:0] exp_q(input logic [15:0] a, input logic [7:0] b);
        if (b == 0) return 16'hFFFF;
        if (APX)    return 16'(((a >> L) / b) << L);
        return a / b;
    endfunction

    function automatic logic [7:0] exp_r(input logic [15:0] a, input logic [7:0] b);
        if (b == 0) return a[7:0];
        if (APX)    return 8'd0;
        return 8'(a % b);
    endfunction

    // Transaction-level model: accepted start -> fixed latency -> done.
    logic        m_busy, m_done, m_z;
    logic [15:0] m_q, m_a;
    logic [7:0]  m_r, m_b;
    int          m_left;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_z <= 1'b0; m_left <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_a    <= A;
                m_b    <= B;
                m_left <= (B == 0) ? 1 : N + 1;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_q    <= exp_q(m_a, m_b);
                m_r    <= exp_r(m_a, m_b);
                m_z    <= (m_b == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("Q", Q, m_q);
            chk("R", R, m_r);
            chk("div_by_zero", div_by_zero, m_z);
        end
    end

    // Called at a negedge; start is sampled on the next posedge.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    logic [15:0] t_a [4];
    logic [7:0]  t_b [4];
    logic [15:0] t_q [4];
    logic [7:0]  t_r [4];
    logic [15:0] e1q, e2q, e3q, e5q;
    logic [7:0]  e1r, e3r;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int ndone;
        logic [15:0] qv;
        logic [7:0]  rv;

        t_a[0] = 16'd0;     t_b[0] = 8'd255;
        t_a[1] = 16'd65535; t_b[1] = 8'd255;
        t_a[2] = 16'd12345; t_b[2] = 8'd13;
        t_a[3] = 16'd255;   t_b[3] = 8'd16;
`ifdef DIV_APPROX_EN
        e1q = 16'd128;   e1r = 8'd0;
        e2q = 16'd65520;
        e3q = 16'd0;     e3r = 8'd0;
        e5q = 16'd0;
        t_q[0] = 16'd0; t_q[1] = 16'd256; t_q[2] = 16'd944; t_q[3] = 16'd0;
        t_r[0] = 8'd0;  t_r[1] = 8'd0;    t_r[2] = 8'd0;    t_r[3] = 8'd0;
`else
        e1q = 16'd142;   e1r = 8'd6;
        e2q = 16'd65535;
        e3q = 16'd0;     e3r = 8'd5;
        e5q = 16'd1;
        t_q[0] = 16'd0; t_q[1] = 16'd257; t_q[2] = 16'd949; t_q[3] = 16'd15;
        t_r[0] = 8'd0;  t_r[1] = 8'd0;    t_r[2] = 8'd8;    t_r[3] = 8'd15;
`endif

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_Q", Q, 16'd0);
        chk("reset_R", R, 8'd0);
        chk("reset_dbz", div_by_zero, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1000 / 7
        run_op(16'd1000, 8'd7, lat);
        chk("t1_latency", lat, N + 2);
        chk("t1_Q", Q, e1q);
        chk("t1_R", R, e1r);
        chk("t1_dbz", div_by_zero, 1'b0);

        // Back-to-back: second start in the idle cycle right after done
        @(negedge clk);
        run_op(16'd65535, 8'd1, lat);
        chk("t2a_Q", Q, e2q);
        chk("t2a_R", R, 8'd0);
        @(negedge clk);
        run_op(16'd5, 8'd200, lat);
        chk("t2b_latency", lat, N + 2);
        chk("t2b_Q", Q, e3q);
        chk("t2b_R", R, e3r);

        // start during the done cycle must be ignored
        A = 16'd9; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", busy, 1'b0);
        @(negedge clk);

        // Divide by zero
        run_op(16'd100, 8'd0, lat);
        chk("t3_latency", lat, 2);
        chk("t3_Q", Q, 16'hFFFF);
        chk("t3_R", R, 8'd100);
        chk("t3_dbz", div_by_zero, 1'b1);

        // start mid-RUN ignored, single done pulse
        @(negedge clk);
        A = 16'd1000; B = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        A = 16'd9; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = '0; B = '0;
        ndone = 0; qv = '0; rv = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin ndone++; qv = Q; rv = R; end
        end
        chk("t4_done_pulses", ndone, 1);
        chk("t4_Q", qv, e1q);
        chk("t4_R", rv, e1r);

        // Reset mid-RUN aborts
        A = 16'd1000; B = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_Q", Q, 16'd0);
        chk("t5_R", R, 8'd0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        run_op(16'd255, 8'd255, lat);
        chk("t5_Q_after", Q, e5q);
        chk("t5_R_after", R, 8'd0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            run_op(t_a[i], t_b[i], lat);
            chk("tbl_latency", lat, N + 2);
            chk("tbl_Q", Q, t_q[i]);
            chk("tbl_R", R, t_r[i]);
        end

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
